// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 13;
    localparam int LANES  = 16;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_CPU,
        BUSY_HOST,
        DONE
    } arb_state_t;

    typedef logic [LANES*DATA_W-1:0] lane_vec_t;

endpackage

// File: rtl/mem_arb_fsm.sv
// Arbiter control: state register, latency counter, host starvation
// counter and registered completion pulses.
module mem_arb_fsm
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT       = 1,
    parameter int HOST_MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cpuReq,
    input  logic hostReq,
    output logic grant,
    output logic grantHost,
    output logic inIdle,
    output logic inDone,
    output logic ownerHost,
    output logic cpuDone,
    output logic hostDone
);

    localparam int SW = $clog2(HOST_MAX_WAIT + 2);

    arb_state_t state;
    arb_state_t nextState;
    logic [2:0]    latCnt;
    logic [SW-1:0] starveCnt;
    logic starved;
    logic bubble;
    logic lastLat;
    logic cpuWin;
    logic hostWin;

    // The cycle carrying a done pulse never arbitrates: the finished
    // requester still holds its request during that cycle.
    assign bubble  = cpuDone | hostDone;
    assign starved = starveCnt == SW'(HOST_MAX_WAIT);
    assign lastLat = latCnt == 3'(MEM_LAT - 1);
    assign hostWin = (state == IDLE) & ~bubble & hostReq
                   & (~cpuReq | starved);
    assign cpuWin  = (state == IDLE) & ~bubble & cpuReq & ~hostWin;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (hostWin)     nextState = BUSY_HOST;
                else if (cpuWin) nextState = BUSY_CPU;
            end
            BUSY_CPU,
            BUSY_HOST: if (lastLat) nextState = DONE;
            DONE:      nextState = IDLE;
            default:   nextState = IDLE;
        endcase
    end

    always_comb begin
        grant     = cpuWin | hostWin;
        grantHost = hostWin;
        inIdle    = state == IDLE;
        inDone    = state == DONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            latCnt    <= '0;
            starveCnt <= '0;
            ownerHost <= 1'b0;
            cpuDone   <= 1'b0;
            hostDone  <= 1'b0;
        end else begin
            cpuDone  <= (state == DONE) & ~ownerHost;
            hostDone <= (state == DONE) & ownerHost;
            if (grant) begin
                latCnt    <= '0;
                ownerHost <= hostWin;
            end else if (state == BUSY_CPU || state == BUSY_HOST) begin
                latCnt <= latCnt + 3'd1;
            end
            if (hostWin)
                starveCnt <= '0;
            else if (cpuWin && hostReq && !starved)
                starveCnt <= starveCnt + SW'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// CPU / host-debug arbiter in front of mem_control.
// Define MEM_ARB_PERF_EN to add the perf_* event counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W        = mem_arb_pkg::ADDR_W,
    parameter int LANES         = mem_arb_pkg::LANES,
    parameter int DATA_W        = mem_arb_pkg::DATA_W,
    parameter int MEM_LAT       = 1,
    parameter int HOST_MAX_WAIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic                    cpu_vec,
    input  logic [ADDR_W-1:0]       cpu_addr,
    input  logic [LANES*DATA_W-1:0] cpu_wdata,
    output logic                    cpu_stall,
    output logic                    cpu_done,
    output logic [LANES*DATA_W-1:0] cpu_rdata,
    input  logic                    host_req,
    input  logic                    host_we,
    input  logic [ADDR_W-1:0]       host_addr,
    input  logic [DATA_W-1:0]       host_wdata,
    output logic                    host_done,
    output logic [DATA_W-1:0]       host_rdata,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_we,
    output logic                    mem_vec,
    output logic [LANES*DATA_W-1:0] mem_wdata,
    input  logic [LANES*DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]             perf_cpu_stall_cnt,
    output logic [31:0]             perf_host_acc_cnt,
    output logic [31:0]             perf_conflict_cnt
`endif
);

    localparam int VW = LANES * DATA_W;

    logic grant;
    logic grantHost;
    logic inIdle;
    logic inDone;
    logic ownerHost;
    logic accWe;

    mem_arb_fsm #(
        .MEM_LAT       (MEM_LAT),
        .HOST_MAX_WAIT (HOST_MAX_WAIT)
    ) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .cpuReq    (cpu_req),
        .hostReq   (host_req),
        .grant     (grant),
        .grantHost (grantHost),
        .inIdle    (inIdle),
        .inDone    (inDone),
        .ownerHost (ownerHost),
        .cpuDone   (cpu_done),
        .hostDone  (host_done)
    );

    assign cpu_stall = rst & cpu_req & ~cpu_done;

    // Command registers load at the grant edge and hold through DONE;
    // the write strobe lives for the issue cycle only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_vec    <= 1'b0;
            mem_wdata  <= '0;
            accWe      <= 1'b0;
            cpu_rdata  <= '0;
            host_rdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (grant) begin
                if (grantHost) begin
                    mem_addr  <= host_addr;
                    mem_vec   <= 1'b0;
                    mem_wdata <= VW'(host_wdata);
                    mem_we    <= host_we;
                    accWe     <= host_we;
                end else begin
                    mem_addr  <= cpu_addr;
                    mem_vec   <= cpu_vec;
                    mem_wdata <= cpu_wdata;
                    mem_we    <= cpu_we;
                    accWe     <= cpu_we;
                end
            end
            if (inDone && !accWe) begin
                if (ownerHost) host_rdata <= mem_rdata[DATA_W-1:0];
                else           cpu_rdata  <= mem_rdata;
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cpu_stall_cnt <= '0;
            perf_host_acc_cnt  <= '0;
            perf_conflict_cnt  <= '0;
        end else begin
            if (cpu_stall)
                perf_cpu_stall_cnt <= perf_cpu_stall_cnt + 32'd1;
            if (host_done)
                perf_host_acc_cnt <= perf_host_acc_cnt + 32'd1;
            if (inIdle && cpu_req && host_req)
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a simple mem_control model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int MEM_LAT = 1;
    localparam int HMW     = 4;
    localparam int VW      = LANES * DATA_W;
    localparam int LAT     = MEM_LAT + 2;
    localparam int PER     = MEM_LAT + 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cpu_req = 1'b0, cpu_we = 1'b0, cpu_vec = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    lane_vec_t cpu_wdata = '0;
    logic cpu_stall, cpu_done;
    lane_vec_t cpu_rdata;
    logic host_req = 1'b0, host_we = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [DATA_W-1:0] host_wdata = '0;
    logic host_done;
    logic [DATA_W-1:0] host_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic mem_we, mem_vec;
    lane_vec_t mem_wdata;
    lane_vec_t mem_rdata = '0;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_cpu_stall_cnt, perf_host_acc_cnt, perf_conflict_cnt;
`endif

    mem_arbiter #(
        .MEM_LAT       (MEM_LAT),
        .HOST_MAX_WAIT (HMW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_vec    (cpu_vec),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_done   (cpu_done),
        .cpu_rdata  (cpu_rdata),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_done  (host_done),
        .host_rdata (host_rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_vec    (mem_vec),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_cpu_stall_cnt (perf_cpu_stall_cnt),
        .perf_host_acc_cnt  (perf_host_acc_cnt),
        .perf_conflict_cnt  (perf_conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int stallCyc = 0;
    int weCyc = 0;

    typedef struct {
        int        doneCyc;
        logic      rd;
        logic      vec;
        lane_vec_t data;
        string     name;
    } exp_t;

    exp_t cpuQ[$];
    exp_t hostQ[$];

    function automatic void chk(string nm, logic [VW-1:0] act,
                                logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // mem_control model: write on the strobe, data one cycle after address
    lane_vec_t memArr [int];
    lane_vec_t cur;
    always @(posedge clk) begin
        if (mem_we) begin
            cur = memArr.exists(int'(mem_addr)) ? memArr[int'(mem_addr)] : '0;
            if (mem_vec) cur = mem_wdata;
            else cur[DATA_W-1:0] = mem_wdata[DATA_W-1:0];
            memArr[int'(mem_addr)] = cur;
        end
        mem_rdata <= memArr.exists(int'(mem_addr)) ? memArr[int'(mem_addr)] : '0;
    end

    // Monitor: pops the scoreboard on every done pulse
    exp_t ec;
    exp_t eh;
    always @(negedge clk) begin
        if (rst) begin
            if (cpu_stall) stallCyc++;
            if (mem_we) weCyc++;
            if (cpu_done) begin
                if (cpuQ.size() == 0) chk("cpu_done unexpected", 1, 0);
                else begin
                    ec = cpuQ.pop_front();
                    chk({ec.name, " done cycle"}, cyc, ec.doneCyc);
                    if (ec.rd && ec.vec)
                        chk({ec.name, " rdata"}, cpu_rdata, ec.data);
                    else if (ec.rd)
                        chk({ec.name, " rdata"}, cpu_rdata[DATA_W-1:0], ec.data);
                end
            end
            if (host_done) begin
                if (hostQ.size() == 0) chk("host_done unexpected", 1, 0);
                else begin
                    eh = hostQ.pop_front();
                    chk({eh.name, " done cycle"}, cyc, eh.doneCyc);
                    if (eh.rd) chk({eh.name, " rdata"}, host_rdata, eh.data);
                end
            end
        end
    end

    task automatic cpuAcc(input logic we, input logic vec,
                          input logic [ADDR_W-1:0] addr, input lane_vec_t wd,
                          input lane_vec_t expD, input int lat,
                          input bit hold, input string nm);
        exp_t e;
        int n;
        cpu_we = we; cpu_vec = vec; cpu_addr = addr; cpu_wdata = wd;
        cpu_req = 1'b1;
        e.doneCyc = cyc + lat; e.rd = ~we; e.vec = vec;
        e.data = expD; e.name = nm;
        cpuQ.push_back(e);
        n = 0;
        do begin @(negedge clk); n++; end while (!cpu_done && n < 64);
        if (!cpu_done) chk({nm, " timeout"}, 0, 1);
        @(posedge clk); #1;
        if (!hold) cpu_req = 1'b0;
    endtask

    task automatic hostAcc(input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wd,
                           input logic [DATA_W-1:0] expD, input int lat,
                           input string nm);
        exp_t e;
        int n;
        host_we = we; host_addr = addr; host_wdata = wd; host_req = 1'b1;
        e.doneCyc = cyc + lat; e.rd = ~we; e.vec = 1'b0;
        e.data = VW'(expD); e.name = nm;
        hostQ.push_back(e);
        n = 0;
        do begin @(negedge clk); n++; end while (!host_done && n < 64);
        if (!host_done) chk({nm, " timeout"}, 0, 1);
        @(posedge clk); #1;
        host_req = 1'b0;
    endtask

    lane_vec_t lanesK;
    lane_vec_t lanesA;
    int s0, w0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < LANES; k++) begin
            lanesK[k*DATA_W +: DATA_W] = DATA_W'(k);
            lanesA[k*DATA_W +: DATA_W] = 32'hA000_0000 + DATA_W'(k);
        end
        memArr['h100] = lanesK;
        memArr['h020] = VW'(32'hCAFE_0020);

        // Reset state, with a request pending to check stall gating
        cpu_req = 1'b1;
        #12;
        chk("reset mem cmd", {mem_we, mem_vec, mem_addr}, 0);
        chk("reset mem_wdata", mem_wdata, 0);
        chk("reset done", {cpu_done, host_done}, 0);
        chk("reset rdata", cpu_rdata | VW'(host_rdata), 0);
        chk("reset stall", cpu_stall, 0);
        cpu_req = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // CPU scalar write then read
        s0 = stallCyc; w0 = weCyc;
        cpuAcc(1, 0, 'h010, VW'(32'hDEAD_BEEF), '0, LAT, 0, "cpu wr");
        chk("wr mem_we cycles", weCyc - w0, 1);
        chk("wr stall cycles", stallCyc - s0, LAT);
`ifdef MEM_ARB_PERF_EN
        chk("perf stall", perf_cpu_stall_cnt, LAT);
`endif
        s0 = stallCyc;
        cpuAcc(0, 0, 'h010, '0, VW'(32'hDEAD_BEEF), LAT, 0, "cpu rd");
        chk("rd stall cycles", stallCyc - s0, LAT);

        // Vector read; check command during the access
        fork
            cpuAcc(0, 1, 'h100, '0, lanesK, LAT, 0, "cpu vrd");
            begin
                @(posedge clk); #1;
                chk("vrd mem_vec", mem_vec, 1);
                chk("vrd mem_addr", mem_addr, 'h100);
            end
        join

        // Vector write then vector read-back
        cpuAcc(1, 1, 'h200, lanesA, '0, LAT, 0, "cpu vwr");
        cpuAcc(0, 1, 'h200, '0, lanesA, LAT, 0, "cpu vrd2");

        // Simultaneous requests: CPU first, host one period later
        fork
            cpuAcc(0, 1, 'h100, '0, lanesK, LAT, 0, "sim cpu");
            hostAcc(0, 'h020, '0, 32'hCAFE_0020, LAT + PER, "sim host");
        join
        chk("cpu_rdata held", cpu_rdata, lanesK);
`ifdef MEM_ARB_PERF_EN
        chk("perf conflict", perf_conflict_cnt, 2);
`endif

        // Host write is forced scalar with lane 0 data only
        cpu_vec = 1'b1;
        fork
            hostAcc(1, 'h030, 32'h1234_5678, '0, LAT, "host wr");
            begin
                @(posedge clk); #1;
                chk("host wr mem_vec", mem_vec, 0);
                chk("host wr mem_wdata", mem_wdata, VW'(32'h1234_5678));
                chk("host wr mem_we", mem_we, 1);
            end
        join
        hostAcc(0, 'h030, '0, 32'h1234_5678, LAT, "host rd");

        // Starvation: host forced in after HMW CPU wins
        fork
            begin
                for (int k = 0; k < HMW; k++)
                    cpuAcc(0, 0, 'h010, '0, VW'(32'hDEAD_BEEF), LAT, 1,
                           "starve cpu");
                cpuAcc(0, 0, 'h030, '0, VW'(32'h1234_5678), LAT + PER, 0,
                       "starve cpu last");
            end
            hostAcc(0, 'h020, '0, 32'hCAFE_0020, LAT + HMW * PER,
                    "starve host");
        join

        // Starvation count cleared: CPU wins the next conflict again
        fork
            cpuAcc(0, 0, 'h010, '0, VW'(32'hDEAD_BEEF), LAT, 0, "post cpu");
            hostAcc(0, 'h030, '0, 32'h1234_5678, LAT + PER, "post host");
        join
`ifdef MEM_ARB_PERF_EN
        chk("perf host acc", perf_host_acc_cnt, 5);
`endif

        // Reset in the middle of a CPU access
        cpu_vec = 1'b1; cpu_we = 1'b0; cpu_addr = 'h100; cpu_req = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst mem cmd", {mem_we, mem_vec, mem_addr}, 0);
        chk("midrst mem_wdata", mem_wdata, 0);
        chk("midrst rdata", cpu_rdata | VW'(host_rdata), 0);
        chk("midrst stall", cpu_stall, 0);
`ifdef MEM_ARB_PERF_EN
        chk("midrst perf", {perf_cpu_stall_cnt, perf_host_acc_cnt,
                            perf_conflict_cnt}, 0);
`endif
        cpu_req = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        cpuAcc(0, 0, 'h010, '0, VW'(32'hDEAD_BEEF), LAT, 0, "after rst");

        repeat (3) @(posedge clk);
        chk("cpu queue drained", cpuQ.size(), 0);
        chk("host queue drained", hostQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences all accesses to the shared data memory controller (16 lanes x 32 bit, vector/scalar modes).
- Arbitrates between two requesters: the CPU load/store port and a host debug port used for external DRAM inspection and loading.
- Sits between the cpu and mem_control blocks in the processor top.
- Drives the CPU stall while the CPU waits on memory or loses arbitration.

Parameters:
- ADDR_W, 13, memory address width
- LANES, 16, vector lanes per access
- DATA_W, 32, bits per lane
- MEM_LAT, 1, cycles from command issue to valid mem_rdata (1..7)
- HOST_MAX_WAIT, 4, cycles a pending host request may lose to the CPU before it is forced to win

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request, held until cpu_done
- cpu_we  in  1  1 = write, 0 = read
- cpu_vec  in  1  1 = vector (all lanes), 0 = scalar (lane 0)
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  LANES x DATA_W  CPU write data
- cpu_stall  out  1  freeze CPU pipeline
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  LANES x DATA_W  read data, held until next CPU read completes
- host_req  in  1  host request, held until host_done
- host_we  in  1  host write
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data (scalar only)
- host_done  out  1  one-cycle completion pulse
- host_rdata  out  DATA_W  lane 0 of read data, held
- mem_addr  out  ADDR_W  to mem_control
- mem_we  out  1  to mem_control
- mem_vec  out  1  to mem_control
- mem_wdata  out  LANES x DATA_W  to mem_control
- mem_rdata  in  LANES x DATA_W  from mem_control

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; any in-flight access is abandoned.
  - All outputs 0, rdata registers 0, starvation counter 0.
  - cpu_stall is 0 during reset.
- States:
  - IDLE: arbitrate this cycle.
  - BUSY_CPU / BUSY_HOST: latency counter runs 0..MEM_LAT-1.
  - DONE: one cycle; captures mem_rdata and pulses done.
- Arbitration in IDLE:
  - CPU has priority by default.
  - Host wins if host_req=1 and cpu_req=0, or if starve_cnt == HOST_MAX_WAIT.
  - Winner registered at the clock edge. Loser keeps waiting; it is never dropped.
- Issue cycle (first BUSY cycle):
  - mem_addr, mem_vec and mem_wdata are registered from the winner.
  - Host accesses force mem_vec=0, with host_wdata placed in lane 0 and other lanes 0.
  - mem_we=winner's we for exactly this one cycle, 0 otherwise.
  - mem_addr, mem_vec and mem_wdata hold until DONE.
- Latency:
  - DONE is entered after MEM_LAT BUSY cycles.
  - Request-to-done = MEM_LAT+2 cycles from the IDLE grant edge (MEM_LAT=1 gives 3).
- DONE:
  - On a read, the winner's rdata register captures mem_rdata.
  - On a write, the rdata register is unchanged.
  - The winner's done pulses high for one cycle, then the FSM returns to IDLE.
  - Back-to-back requests re-arbitrate in the next IDLE cycle, so there is one idle bubble per access.
- starve_cnt:
  - Increments (saturating) on each IDLE cycle in which host_req=1 and CPU wins.
  - Clears when the host is granted.
- cpu_stall = cpu_req & ~cpu_done (combinational from registered cpu_done).
- Requester inputs are sampled only at grant. Changes mid-access are ignored.
- Simultaneous requests: CPU first; the host follows in the next arbitration unless starved.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- With the macro defined:
  - Adds outputs perf_cpu_stall_cnt, perf_host_acc_cnt and perf_conflict_cnt, each 32 bit.
  - perf_cpu_stall_cnt counts cycles with cpu_stall=1.
  - perf_host_acc_cnt counts host_done pulses.
  - perf_conflict_cnt counts IDLE cycles with both requests high.
  - All three wrap at 2^32 and reset to 0.
  - Intended to feed perfRegister.
- Without the macro: the ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {IDLE, BUSY_CPU, BUSY_HOST, DONE}
  - lane_vec_t (LANES x DATA_W packed)
  - Default constants ADDR_W, LANES, DATA_W
- Sub-module mem_arb_fsm: state register, latency counter and starvation counter, producing grant/phase signals.
- The top level holds the datapath registers and muxing.

Test Plan:
- CPU scalar write then read: write addr 0x010 with 0xDEADBEEF, then read it.
  - mem_we high exactly 1 cycle; cpu_done 3 cycles after each grant.
  - cpu_rdata lane0 = 0xDEADBEEF; cpu_stall high 3 cycles per access.
- CPU vector read, addr 0x100, memory lanes = 0..15: cpu_rdata lane k = k, and mem_vec=1 during the access.
- Simultaneous cpu_req and host_req (host read 0x020): CPU completes first, host_done follows 4 cycles after cpu_done, host_rdata = memory value.
- Starvation: cpu_req held continuously and host_req held.
  - Host is granted after 4 CPU wins.
  - starve_cnt clears to 0 on that grant.
- Reset mid-access: rst=0 during BUSY_CPU.
  - All outputs go to 0 immediately.
  - After release the FSM is in IDLE, no done pulse occurs, and the next request completes normally.
- MEM_LAT=3 build: cpu read latency = 5 cycles. With MEM_ARB_PERF_EN defined, perf_cpu_stall_cnt = 5 after one read.
